// File: rtl/cic_interp_4stage.sv
// Four-stage CIC interpolator with run-time rate R in {4,8,16,32,64,128} and unity DC gain.
// Optional macro CIC_INTERP_ROUND_EN: round half up ahead of the gain shift (default truncates).
module cic_interp_4stage #(
  parameter int INPUT_WIDTH  = 16,
  parameter int OUTPUT_WIDTH = 16,
  parameter int ACC_WIDTH    = 40
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [7:0]              interp_rate,
  input  logic [INPUT_WIDTH-1:0]  din,
  output logic                    strobe_in,
  output logic [OUTPUT_WIDTH-1:0] dout
);

  localparam int NSTG = 4;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    {{(ACC_WIDTH+2-OUTPUT_WIDTH){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    {{(ACC_WIDTH+2-OUTPUT_WIDTH){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  function automatic logic [7:0] legal_rate(input logic [7:0] r);
    case (r)
      8'd4, 8'd8, 8'd16, 8'd32, 8'd64, 8'd128: legal_rate = r;
      default:                                 legal_rate = 8'd4;
    endcase
  endfunction

  // Shift of 3*log2(R) cancels the R^3 gain of the comb/integrator cascade.
  function automatic logic [4:0] gain_shift(input logic [7:0] r);
    case (r)
      8'd8:    gain_shift = 5'd9;
      8'd16:   gain_shift = 5'd12;
      8'd32:   gain_shift = 5'd15;
      8'd64:   gain_shift = 5'd18;
      8'd128:  gain_shift = 5'd21;
      default: gain_shift = 5'd6;
    endcase
  endfunction

  logic [6:0]                  cnt_q, cnt_d;
  logic [7:0]                  rate_q, rate_d, rate_new;
  logic signed [ACC_WIDTH-1:0] comb_dly_q [NSTG];
  logic signed [ACC_WIDTH-1:0] comb_dly_d [NSTG];
  logic signed [ACC_WIDTH-1:0] comb_x     [NSTG+1];
  logic signed [ACC_WIDTH-1:0] c_q, c_d;
  logic                        stb_q, stb_d;
  logic signed [ACC_WIDTH-1:0] integ_q [NSTG];
  logic signed [ACC_WIDTH-1:0] integ_d [NSTG];
  logic signed [ACC_WIDTH-1:0] u;
  logic [OUTPUT_WIDTH-1:0]     dout_q, dout_d;
  logic [4:0]                  shamt;
  logic signed [ACC_WIDTH:0]   i3_ext, shifted;
`ifdef CIC_INTERP_ROUND_EN
  logic signed [ACC_WIDTH:0]   rnd_bias, i3_rnd;
`endif
  logic                        cnt_wrap, clear;

  always_comb begin
    rate_new  = legal_rate(interp_rate);
    strobe_in = enable & ~reset & (cnt_q == 7'd0);
    cnt_wrap  = ({1'b0, cnt_q} == rate_q - 8'd1);

    // Comb section runs at the low rate: delays move only when a sample is taken.
    comb_x[0] = ACC_WIDTH'($signed(din));
    for (int k = 0; k < NSTG; k++) begin
      comb_x[k+1]   = comb_x[k] - comb_dly_q[k];
      comb_dly_d[k] = strobe_in ? comb_x[k] : comb_dly_q[k];
    end
    c_d   = strobe_in ? comb_x[NSTG] : c_q;
    stb_d = strobe_in;

    // Zero-stuffing: the comb result feeds the integrators for one cycle only.
    u = stb_q ? c_q : '0;
    integ_d[0] = integ_q[0] + u;
    for (int k = 1; k < NSTG; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end

    shamt  = gain_shift(rate_q);
    i3_ext = {integ_q[NSTG-1][ACC_WIDTH-1], integ_q[NSTG-1]};
`ifdef CIC_INTERP_ROUND_EN
    rnd_bias = (ACC_WIDTH+1)'(1) << (shamt - 5'd1);
    i3_rnd   = i3_ext + rnd_bias;
    shifted  = i3_rnd >>> shamt;
`else
    shifted  = i3_ext >>> shamt;
`endif

    if (shifted > SAT_MAX) begin
      dout_d = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      dout_d = {1'b1, {(OUTPUT_WIDTH-1){1'b0}}};
    end else begin
      dout_d = shifted[OUTPUT_WIDTH-1:0];
    end

    cnt_d  = cnt_wrap ? 7'd0 : cnt_q + 7'd1;
    rate_d = rate_q;
    clear  = 1'b0;
    if (cnt_wrap) begin
      rate_d = rate_new;
      clear  = (rate_new != rate_q);
    end
    if (!enable) begin
      cnt_d  = 7'd0;
      rate_d = rate_q;
      clear  = 1'b1;
    end

    // A rate change invalidates everything in flight, since the gain shift changes too.
    if (clear) begin
      c_d    = '0;
      stb_d  = 1'b0;
      dout_d = '0;
      for (int k = 0; k < NSTG; k++) begin
        comb_dly_d[k] = '0;
        integ_d[k]    = '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q  <= '0;
      rate_q <= legal_rate(interp_rate);
      c_q    <= '0;
      stb_q  <= 1'b0;
      dout_q <= '0;
      for (int k = 0; k < NSTG; k++) begin
        comb_dly_q[k] <= '0;
        integ_q[k]    <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      rate_q <= rate_d;
      c_q    <= c_d;
      stb_q  <= stb_d;
      dout_q <= dout_d;
      for (int k = 0; k < NSTG; k++) begin
        comb_dly_q[k] <= comb_dly_d[k];
        integ_q[k]    <= integ_d[k];
      end
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_cic_interp_4stage.sv
// Self-checking bench for cic_interp_4stage: convolution-based reference model plus literal checks.
// A second instance with a 12-bit output exercises the saturation path.
module tb_cic_interp_4stage;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [7:0]  interp_rate;
  logic [15:0] din;
  logic        strobe_in, strobe_s;
  logic [15:0] dout;
  logic [11:0] dout_s;

  always #5 clk = ~clk;

  cic_interp_4stage u_dut (
    .clock(clk), .reset(reset), .enable(enable), .interp_rate(interp_rate),
    .din(din), .strobe_in(strobe_in), .dout(dout)
  );

  cic_interp_4stage #(.OUTPUT_WIDTH(12)) u_dut_s (
    .clock(clk), .reset(reset), .enable(enable), .interp_rate(interp_rate),
    .din(din), .strobe_in(strobe_s), .dout(dout_s)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: output = sum of low-rate samples times (box_R)^4 impulse response, scaled.
  typedef struct { longint x; longint t; } samp_t;
  samp_t  hist[$];
  longint h [512];
  int     h_len = 1;
  int     m_rate = 4;
  int     m_phase = 0;
  longint m_dout = 0, m_dout12 = 0;
  longint cyc = 0;
  bit     chk_on = 1'b0;

  function automatic int legal(input int r);
    case (r)
      4, 8, 16, 32, 64, 128: return r;
      default:               return 4;
    endcase
  endfunction

  function automatic int log2r(input int r);
    int n = 0;
    while ((1 << n) < r) n++;
    return n;
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint lim;
    lim = 64'sd1 <<< (w - 1);
    if (v > lim - 1) return lim - 1;
    if (v < -lim)    return -lim;
    return v;
  endfunction

  task automatic build_h(input int r);
    longint tmp [512];
    int len;
    for (int i = 0; i < 512; i++) h[i] = 0;
    for (int i = 0; i < r; i++) h[i] = 1;
    len = r;
    repeat (3) begin
      for (int j = 0; j < len + r - 1; j++) begin
        tmp[j] = 0;
        for (int i = 0; i < r; i++)
          if (j - i >= 0 && j - i < len) tmp[j] += h[j - i];
      end
      len = len + r - 1;
      for (int j = 0; j < len; j++) h[j] = tmp[j];
    end
    h_len = len;
  endtask

  task automatic model_step();
    bit     stb;
    longint acc, y;
    int     s, j, newr;
    samp_t  sm;
    stb = enable && !reset && (m_phase == 0);
    if (reset) begin
      hist.delete();
      m_rate = legal(int'(interp_rate));
      build_h(m_rate);
      m_phase = 0; m_dout = 0; m_dout12 = 0;
    end else if (!enable) begin
      hist.delete();
      m_phase = 0; m_dout = 0; m_dout12 = 0;
    end else begin
      acc = 0;
      foreach (hist[k]) begin
        j = int'(cyc - hist[k].t - 5);
        if (j >= 0 && j < h_len) acc += hist[k].x * h[j];
      end
      s = 3 * log2r(m_rate);
`ifdef CIC_INTERP_ROUND_EN
      y = (acc + (64'sd1 <<< (s - 1))) >>> s;
`else
      y = acc >>> s;
`endif
      m_dout   = sat(y, 16);
      m_dout12 = sat(y, 12);
      if (stb) begin
        sm.x = longint'($signed(din));
        sm.t = cyc;
        hist.push_back(sm);
      end
      if (m_phase == m_rate - 1) begin
        m_phase = 0;
        newr = legal(int'(interp_rate));
        if (newr != m_rate) begin
          m_rate = newr;
          build_h(m_rate);
          hist.delete();
          m_dout = 0; m_dout12 = 0;
        end
      end else begin
        m_phase++;
      end
    end
    while (hist.size() > 0 && cyc - hist[0].t - 5 >= h_len) void'(hist.pop_front());
    cyc++;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("strobe_in",    {63'd0, strobe_in}, {63'd0, (enable && !reset && m_phase == 0)});
      chk("strobe_sat12", {63'd0, strobe_s},  {63'd0, (enable && !reset && m_phase == 0)});
      chk("dout",         $signed(dout),      m_dout);
      chk("dout_sat12",   $signed(dout_s),    m_dout12);
    end
  end

  // Stimulus
  int          mode = 0;
  logic [15:0] cval = '0;
  bit          alt = 1'b0;

  task automatic tick();
    @(posedge clk);
    #1;
    case (mode)
      0: din = cval;
      1: din = 16'($urandom);
      2: if (enable && m_phase == 0) begin
           din = alt ? 16'h7FFF : 16'h8000;
           alt = ~alt;
         end
      default: ;
    endcase
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input logic [7:0] r);
    reset = 1'b1;
    interp_rate = r;
    tick();
    reset = 1'b0;
  endtask

  task automatic next_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!strobe_in && n < 300);
  endtask

  initial begin
    int     n, per, t, first_t;
    longint sum, first_v;
    bit     seen_hi, seen_lo;
    int     rates [8] = '{4, 8, 16, 0, 32, 64, 200, 128};

    reset = 1'b1; enable = 1'b0; interp_rate = 8'd4; din = '0;
    @(posedge clk); #1;
    chk_on = 1'b1;

    // Idle with enable low, then the first enabled cycle must strobe.
    reset = 1'b0;
    run(3);
    chk("idle_dout", $signed(dout), 0);
    chk("idle_strobe", {63'd0, strobe_in}, 0);
    enable = 1'b1;
    #1;
    chk("first_strobe", {63'd0, strobe_in}, 1);

    // R=4, DC 0x0100
    mode = 0; cval = 16'h0100;
    do_reset(8'd4);
    run(60);
    for (int i = 0; i < 8; i++) begin
      chk("dc_r4", $signed(dout), 16'sh0100);
      tick();
    end

    // Illegal rate 5 behaves as R=4
    do_reset(8'd5);
    run(60);
    next_strobe(n);
    next_strobe(per);
    chk("rate5_period", per, 4);
    chk("rate5_dc", $signed(dout), 16'sh0100);

    // R=8 impulse: latency and area
    cval = '0;
    do_reset(8'd8);
    run(20);
    n = 0;
    while (m_phase != 0 && n < 20) begin tick(); n++; end
    din = 16'h4000;
    t = int'(cyc);
    sum = 0; first_t = -1; first_v = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      sum += longint'($signed(dout));
      if (first_t < 0 && dout != 16'h0) begin
        first_t = int'(cyc);
        first_v = longint'($signed(dout));
      end
    end
    chk("impulse_latency", first_t - t, 6);
    chk("impulse_first", first_v, 32);
    chk("impulse_sum", sum, 64'sh20000);

    // R=4 full-scale alternating input; the 12-bit instance must clip both ways.
    mode = 2; alt = 1'b1;
    do_reset(8'd4);
    seen_hi = 1'b0; seen_lo = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (dout_s == 12'h7FF) seen_hi = 1'b1;
      if (dout_s == 12'h800) seen_lo = 1'b1;
    end
    chk("sat12_hi_seen", {63'd0, seen_hi}, 1);
    chk("sat12_lo_seen", {63'd0, seen_lo}, 1);

    // Rate change 16 -> 64 mid-stream with DC 0x1000
    mode = 0; cval = 16'h1000;
    do_reset(8'd16);
    run(100);
    chk("dc_r16", $signed(dout), 16'sh1000);
    run(5);
    interp_rate = 8'd64;
    next_strobe(n);
    chk("rate_chg_clear", $signed(dout), 0);
    next_strobe(per);
    chk("period_r64", per, 64);
    run(400);
    for (int i = 0; i < 4; i++) begin
      chk("dc_r64", $signed(dout), 16'sh1000);
      tick();
    end

    // Reset pulse during random streaming
    mode = 1;
    do_reset(8'd32);
    run(300);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("rst_dout", $signed(dout), 0);
    chk("rst_strobe", {63'd0, strobe_in}, 1);
    run(200);

    // Enable dropped mid-stream
    enable = 1'b0;
    run(5);
    chk("en_low_dout", $signed(dout), 0);
    chk("en_low_strobe", {63'd0, strobe_in}, 0);
    enable = 1'b1;
    #1;
    chk("en_rise_strobe", {63'd0, strobe_in}, 1);

    // Random streaming across every rate, including illegal codes, without reset
    foreach (rates[k]) begin
      interp_rate = 8'(rates[k]);
      run(5 * legal(rates[k]) + 100);
    end

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
